// File: rtl/microprocessor_valve_pio_pkg.sv
// Shared register map and read-bus width for the valve output PIO.
package microprocessor_valve_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA      = 2'd0,
    ADDR_PULSE_LEN = 2'd1,
    ADDR_OUTSET    = 2'd2,
    ADDR_OUTCLEAR  = 2'd3
  } pio_addr_e;

  localparam int unsigned READ_WIDTH = 32;

endpackage

// File: rtl/microprocessor_pio_pulse_timer.sv
// Pulse countdown for bits raised through outset: tracks which bits to drop
// and flags the cycle in which they expire.
module microprocessor_pio_pulse_timer #(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned PULSE_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PULSE_WIDTH-1:0] pulse_len,
  input  logic                   set_en,
  input  logic [DATA_WIDTH-1:0]  set_bits,
  input  logic                   clr_en,
  input  logic [DATA_WIDTH-1:0]  clr_bits,
  input  logic                   cancel,
  output logic [DATA_WIDTH-1:0]  pulse_mask,
  output logic [PULSE_WIDTH-1:0] count,
  output logic                   expire,
  output logic                   busy
);

  logic [DATA_WIDTH-1:0]  mask_next;
  logic [PULSE_WIDTH-1:0] count_next;

  assign busy   = (count != '0);
  // Any outset or data write in the final cycle pre-empts expiry.
  assign expire = (count == PULSE_WIDTH'(1)) && !set_en && !cancel;

  always_comb begin
    mask_next  = pulse_mask;
    count_next = count;
    if (cancel) begin
      mask_next  = '0;
      count_next = '0;
    end else if (set_en) begin
      if ((pulse_len != '0) && ((set_bits != '0) || (pulse_mask != '0))) begin
        mask_next  = pulse_mask | set_bits;
        count_next = pulse_len;
      end
    end else begin
      if (busy) count_next = count - PULSE_WIDTH'(1);
      if (expire) mask_next = '0;
      if (clr_en) begin
        mask_next = mask_next & ~clr_bits;
        if (mask_next == '0) count_next = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_mask <= '0;
      count      <= '0;
    end else begin
      pulse_mask <= mask_next;
      count      <= count_next;
    end
  end

endmodule

// File: rtl/microprocessor_valve_pio.sv
// Avalon-MM output PIO for valve/indicator lines with atomic set/clear and
// optional timed auto-clear of bits raised through outset.
module microprocessor_valve_pio
  import microprocessor_valve_pio_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH  = 4,
  parameter int unsigned          PULSE_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [READ_WIDTH-1:0] readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  pulse_busy
);

  pio_addr_e              addr;
  logic                   wr;
  logic [DATA_WIDTH-1:0]  wd_data;
  logic [PULSE_WIDTH-1:0] wd_pulse;
  logic                   unused_wd;

  logic [DATA_WIDTH-1:0]  data_reg, data_next;
  logic [PULSE_WIDTH-1:0] pulse_len;
  logic [DATA_WIDTH-1:0]  pulse_mask;
  logic [PULSE_WIDTH-1:0] count;
  logic                   expire;
  logic [READ_WIDTH-1:0]  rd_next;

  assign addr      = pio_addr_e'(address);
  assign wr        = chipselect & ~write_n;
  assign wd_data   = writedata[DATA_WIDTH-1:0];
  assign wd_pulse  = writedata[PULSE_WIDTH-1:0];
  assign unused_wd = ^writedata;

  microprocessor_pio_pulse_timer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PULSE_WIDTH (PULSE_WIDTH)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .pulse_len  (pulse_len),
    .set_en     (wr && (addr == ADDR_OUTSET)),
    .set_bits   (wd_data),
    .clr_en     (wr && (addr == ADDR_OUTCLEAR)),
    .clr_bits   (wd_data),
    .cancel     (wr && (addr == ADDR_DATA)),
    .pulse_mask (pulse_mask),
    .count      (count),
    .expire     (expire),
    .busy       (pulse_busy)
  );

  // Expiry is applied first so an outclear in the same cycle stacks on top of it.
  always_comb begin
    data_next = data_reg;
    if (expire) data_next = data_reg & ~pulse_mask;
    if (wr) begin
      case (addr)
        ADDR_DATA:     data_next = wd_data;
        ADDR_OUTSET:   data_next = data_reg | wd_data;
        ADDR_OUTCLEAR: data_next = data_next & ~wd_data;
        default:       ;
      endcase
    end
  end

  always_comb begin
    rd_next = '0;
    case (addr)
      ADDR_DATA:      rd_next = READ_WIDTH'(data_reg);
      ADDR_PULSE_LEN: rd_next = READ_WIDTH'(pulse_len);
      ADDR_OUTSET:    rd_next = READ_WIDTH'(pulse_mask);
      ADDR_OUTCLEAR:  rd_next = READ_WIDTH'(count);
      default:        ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg  <= RESET_VALUE;
      pulse_len <= '0;
      readdata  <= '0;
    end else begin
      data_reg <= data_next;
      readdata <= rd_next;
      if (wr && (addr == ADDR_PULSE_LEN)) pulse_len <= wd_pulse;
    end
  end

  assign out_port = data_reg;

endmodule

// File: tb/tb_microprocessor_valve_pio.sv
// Directed, table-driven bench for microprocessor_valve_pio.
module tb_microprocessor_valve_pio;

  localparam logic [3:0] RV = 4'h6;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;
  logic        pulse_busy;

  int n_vec = 0;
  int n_err = 0;

  microprocessor_valve_pio #(
    .DATA_WIDTH  (4),
    .PULSE_WIDTH (16),
    .RESET_VALUE (RV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .pulse_busy (pulse_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        wn;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [3:0]  out;
    logic        busy;
    logic [31:0] rd;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(logic cs, logic wn, logic [1:0] a, logic [31:0] wd,
                              logic [3:0] o, logic b, logic [31:0] rd);
    vec_t t;
    t.cs = cs; t.wn = wn; t.addr = a; t.wd = wd; t.out = o; t.busy = b; t.rd = rd;
    return t;
  endfunction

  function automatic vec_t wv(logic [1:0] a, logic [31:0] wd, logic [3:0] o, logic b, logic [31:0] rd);
    return mk(1'b1, 1'b0, a, wd, o, b, rd);
  endfunction

  function automatic vec_t iv(logic [1:0] a, logic [3:0] o, logic b, logic [31:0] rd);
    return mk(1'b1, 1'b1, a, 32'hFFFF_FFFF, o, b, rd);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive, take the edge, settle 1ns after it.
  task automatic cycle(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // basic writes/reads
    v.push_back(iv(0, 4'h6, 0, 32'h6));
    v.push_back(iv(1, 4'h6, 0, 32'h0));
    v.push_back(iv(2, 4'h6, 0, 32'h0));
    v.push_back(iv(3, 4'h6, 0, 32'h0));
    v.push_back(wv(0, 32'hA, 4'hA, 0, 32'h6));
    v.push_back(iv(0, 4'hA, 0, 32'hA));
    v.push_back(wv(0, 32'hFFFF_FFF0, 4'h0, 0, 32'hA));
    // pulse_len=3, single pulse
    v.push_back(wv(1, 32'h3, 4'h0, 0, 32'h0));
    v.push_back(wv(2, 32'h1, 4'h1, 1, 32'h0));
    v.push_back(iv(3, 4'h1, 1, 32'h3));
    v.push_back(iv(3, 4'h1, 1, 32'h2));
    v.push_back(iv(2, 4'h0, 0, 32'h1));
    v.push_back(iv(2, 4'h0, 0, 32'h0));
    // pulse_len=4, retrigger two cycles in
    v.push_back(wv(1, 32'h4, 4'h0, 0, 32'h3));
    v.push_back(wv(2, 32'h1, 4'h1, 1, 32'h0));
    v.push_back(iv(3, 4'h1, 1, 32'h4));
    v.push_back(wv(2, 32'h2, 4'h3, 1, 32'h1));
    v.push_back(iv(3, 4'h3, 1, 32'h4));
    v.push_back(iv(3, 4'h3, 1, 32'h3));
    v.push_back(iv(3, 4'h3, 1, 32'h2));
    v.push_back(iv(3, 4'h0, 0, 32'h1));
    v.push_back(iv(2, 4'h0, 0, 32'h0));
    // pulse_len=0: plain set/clear
    v.push_back(wv(1, 32'h0, 4'h0, 0, 32'h4));
    v.push_back(wv(2, 32'h3, 4'h3, 0, 32'h0));
    v.push_back(wv(3, 32'h1, 4'h2, 0, 32'h0));
    v.push_back(iv(0, 4'h2, 0, 32'h2));
    // data write cancels pulse
    v.push_back(wv(1, 32'h5, 4'h2, 0, 32'h0));
    v.push_back(wv(2, 32'h8, 4'hA, 1, 32'h0));
    v.push_back(wv(0, 32'h1, 4'h1, 0, 32'hA));
    v.push_back(iv(2, 4'h1, 0, 32'h0));
    v.push_back(iv(3, 4'h1, 0, 32'h0));
    // partial outclear keeps counting, full outclear stops
    v.push_back(wv(2, 32'h6, 4'h7, 1, 32'h0));
    v.push_back(wv(3, 32'h2, 4'h5, 1, 32'h5));
    v.push_back(iv(3, 4'h5, 1, 32'h4));
    v.push_back(wv(3, 32'h4, 4'h1, 0, 32'h3));
    v.push_back(iv(2, 4'h1, 0, 32'h0));
    // outset of 0 with empty mask does nothing
    v.push_back(wv(2, 32'h0, 4'h1, 0, 32'h0));
    v.push_back(iv(3, 4'h1, 0, 32'h0));
    // pulse_len upper bits ignored
    v.push_back(wv(1, 32'h0001_0002, 4'h1, 0, 32'h5));
    v.push_back(iv(1, 4'h1, 0, 32'h2));
    // outclear in expiry cycle
    v.push_back(wv(2, 32'h4, 4'h5, 1, 32'h0));
    v.push_back(iv(3, 4'h5, 1, 32'h2));
    v.push_back(wv(3, 32'h4, 4'h1, 0, 32'h1));
    v.push_back(iv(3, 4'h1, 0, 32'h0));
    // outset in expiry cycle retriggers
    v.push_back(wv(2, 32'h4, 4'h5, 1, 32'h0));
    v.push_back(iv(3, 4'h5, 1, 32'h2));
    v.push_back(wv(2, 32'h4, 4'h5, 1, 32'h4));
    v.push_back(iv(3, 4'h5, 1, 32'h2));
    v.push_back(iv(3, 4'h1, 0, 32'h1));
    v.push_back(wv(2, 32'h2, 4'h3, 1, 32'h0));
    v.push_back(iv(3, 4'h3, 1, 32'h2));
    v.push_back(wv(2, 32'h8, 4'hB, 1, 32'h2));
    v.push_back(iv(3, 4'hB, 1, 32'h2));
    v.push_back(iv(2, 4'h1, 0, 32'hA));
    // data write in expiry cycle
    v.push_back(wv(2, 32'h4, 4'h5, 1, 32'h0));
    v.push_back(iv(3, 4'h5, 1, 32'h2));
    v.push_back(wv(0, 32'hC, 4'hC, 0, 32'h5));
    v.push_back(iv(2, 4'hC, 0, 32'h0));
    // write strobe qualification
    v.push_back(mk(1'b0, 1'b0, 2'd0, 32'hF, 4'hC, 0, 32'hC));
    v.push_back(mk(1'b1, 1'b1, 2'd0, 32'h3, 4'hC, 0, 32'hC));

    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    #1;
    check("reset out_port", 32'(out_port), 32'(RV));
    check("reset pulse_busy", 32'(pulse_busy), 32'h0);
    check("reset readdata", readdata, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < v.size(); i++) begin
      cycle(v[i].cs, v[i].wn, v[i].addr, v[i].wd);
      check($sformatf("v%0d out_port", i), 32'(out_port), 32'(v[i].out));
      check($sformatf("v%0d pulse_busy", i), 32'(pulse_busy), 32'(v[i].busy));
      check($sformatf("v%0d readdata", i), readdata, v[i].rd);
    end

    // asynchronous reset mid-pulse
    cycle(1'b1, 1'b0, 2'd1, 32'h5);
    cycle(1'b1, 1'b0, 2'd2, 32'h1);
    cycle(1'b1, 1'b1, 2'd3, 32'h0);
    check("midpulse out_port", 32'(out_port), 32'hD);
    check("midpulse count", readdata, 32'h5);
    #2;
    reset = 1'b1;
    #1;
    check("async reset out_port", 32'(out_port), 32'(RV));
    check("async reset pulse_busy", 32'(pulse_busy), 32'h0);
    check("async reset readdata", readdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      cycle(1'b1, 1'b1, 2'(a), 32'h0);
      check($sformatf("post-reset rd a%0d", a), readdata, (a == 0) ? 32'(RV) : 32'h0);
      check($sformatf("post-reset out a%0d", a), 32'(out_port), 32'(RV));
      check($sformatf("post-reset busy a%0d", a), 32'(pulse_busy), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/microprocessor_valve_pio.md
Name: microprocessor_valve_pio

Overview:
Avalon-MM output PIO slave that drives the bathysphere valve and indicator lines; it is the write-side counterpart of the input status PIOs. The Nios II writes a data register, and can set or clear individual bits atomically. Bits set through the set register can optionally auto-clear after a programmed number of clocks, which lets software issue timed valve pulses. The block sits on the system interconnect beside the input PIOs, and out_port goes to the top level.

Parameters:
DATA_WIDTH, 4, number of output bits on out_port (1..32)
PULSE_WIDTH, 16, width of the pulse-length register and countdown counter (1..32)
RESET_VALUE, 0, value of the data register after reset

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
address  input  2  register select: 0 data, 1 pulse_len, 2 outset, 3 outclear
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
readdata  output  32  registered read data
out_port  output  DATA_WIDTH  drives the valves; equals data_reg
pulse_busy  output  1  high while the pulse countdown is nonzero

Behaviour:
- Write strobe wr = chipselect & ~write_n. Only bits [DATA_WIDTH-1:0] or [PULSE_WIDTH-1:0] of writedata are used; the upper bits are ignored.
- State and reset values: data_reg = RESET_VALUE, pulse_len = 0, pulse_mask = 0, count = 0, readdata = 0. Reset is asynchronous and takes effect immediately, including mid-pulse; out_port returns to RESET_VALUE.
- addr 0 write: data_reg <= wd. Also pulse_mask <= 0 and count <= 0, so any active pulse is cancelled.
- addr 1 write: pulse_len <= wd. A running countdown is unaffected; the new value applies from the next outset.
- addr 2 write (outset): data_reg <= data_reg | wd.
  - If pulse_len != 0: pulse_mask <= pulse_mask | wd and count <= pulse_len. This reloads (retriggers) any running pulse.
  - If pulse_len == 0: the bits stay set, and pulse_mask and count are unchanged.
- addr 3 write (outclear): data_reg <= data_reg & ~wd and pulse_mask <= pulse_mask & ~wd. If the resulting mask is 0, count <= 0.
- Countdown: when count != 0 and no outset/data write occurs in that cycle, count <= count - 1.
- Expiry: the transition of count from 1 to 0 clears data_reg bits in pulse_mask and sets pulse_mask <= 0. A pulsed bit is therefore high for exactly pulse_len cycles after the write edge.
- Simultaneous events:
  - outset in the expiry cycle: the reload wins, and the previous mask bits stay high.
  - data write in the expiry cycle: the data write wins.
  - outclear in the expiry cycle: both apply, so data_reg <= data_reg & ~wd & ~pulse_mask, and mask and count go to 0.
- outset with wd = 0 and pulse_len != 0 reloads count only if pulse_mask != 0; otherwise it has no effect.
- pulse_busy = (count != 0), combinational from the register.
- Read path: readdata is updated every cycle (no read strobe), zero-extended to 32 bits, with latency 1.
  - addr 0: data_reg
  - addr 1: pulse_len
  - addr 2: pulse_mask
  - addr 3: count
  - The value reflects register state before any same-cycle write.
- Widths: count is PULSE_WIDTH bits. The maximum pulse is 2^PULSE_WIDTH - 1 cycles. There is no wrap: the decrement stops at 0.

Decomposition:
- Shared package: address offset constants (ADDR_DATA=0, ADDR_PULSE_LEN=1, ADDR_OUTSET=2, ADDR_OUTCLEAR=3) and the readdata zero-extension width (32).
- One natural sub-module: microprocessor_pio_pulse_timer. It holds pulse_mask and count, takes load/clear/cancel inputs, and outputs expire and busy.
- The data register and read mux stay in the top module.

Test Plan:
- Reset asserted mid-pulse (count=5) -> out_port=RESET_VALUE, pulse_busy=0, readdata=0 immediately; all registers read 0/RESET_VALUE after release.
- Write addr0=0xA, then read addr0 -> out_port=4'hA from the next edge; readdata=0x0000000A one cycle after address=0 is presented.
- pulse_len=3, outset 0x1 with data=0 -> out_port[0] high for exactly 3 cycles; pulse_busy high for the same 3 cycles; then out_port=0 and mask=0.
- pulse_len=4, outset 0x1, and 2 cycles later outset 0x2 -> both bits high; count reloads to 4; both bits clear together 4 cycles after the second write.
- pulse_len=0, outset 0x3, then outclear 0x1 -> out_port=0x3, then 0x2; pulse_busy stays 0 throughout.
- pulse_len=2, outset 0x4, then outclear 0x4 in the expiry cycle -> out_port=0, count=0; no residual pulse. A separate run with outset 0x4 in the expiry cycle keeps the bit high for 2 more cycles.
